// File: rtl/text_screen_tdpram.sv
// Text-cell store: true dual-port 64-bit RAM with per-byte write enables.
// Port A (bus side) reads through two registers, port B (display fetch) through one.
module text_screen_tdpram #(
  parameter int TEXT_CELL_COUNT = 16384,
  parameter int AWID            = $clog2(TEXT_CELL_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ena_i,
  input  logic [7:0]      wea_i,
  input  logic [AWID-1:0] adra_i,
  input  logic [63:0]     dina_i,
  output logic [63:0]     douta_o,
  input  logic            enb_i,
  input  logic [7:0]      web_i,
  input  logic [AWID-1:0] adrb_i,
  input  logic [63:0]     dinb_i,
  output logic [63:0]     doutb_o
);

  logic [63:0] mem [TEXT_CELL_COUNT] = '{default: '0};
  logic [63:0] rda;
  logic        rd_a;
  logic        rd_b;

  assign rd_a = ena_i && (wea_i == 8'h00);
  assign rd_b = enb_i && (web_i == 8'h00);

  // Port B bytes are applied first so port A wins on a same-address, same-byte clash.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 8; i++) begin
      if (enb_i && web_i[i]) mem[adrb_i][8*i +: 8] <= dinb_i[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      if (ena_i && wea_i[i]) mem[adra_i][8*i +: 8] <= dina_i[8*i +: 8];
    end
  end

  // Reads sample the pre-edge array, so a cross-port read of a written cell sees old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rda     <= '0;
      douta_o <= '0;
      doutb_o <= '0;
    end else begin
      if (rd_a) rda <= mem[adra_i];
      douta_o <= rda;
      if (rd_b) doutb_o <= mem[adrb_i];
    end
  end

endmodule

// File: tb/tb_text_screen_tdpram.sv
// Directed bench for text_screen_tdpram: latency, byte enables, no-change, collisions, reset.
module tb_text_screen_tdpram;
  localparam int AWID = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena, enb;
  logic [7:0]      wea, web;
  logic [AWID-1:0] adra, adrb;
  logic [63:0]     dina, dinb;
  logic [63:0]     douta, doutb;

  int n_chk  = 0;
  int n_fail = 0;

  text_screen_tdpram dut (
    .clk_i(clk), .rst_i(rst),
    .ena_i(ena), .wea_i(wea), .adra_i(adra), .dina_i(dina), .douta_o(douta),
    .enb_i(enb), .web_i(web), .adrb_i(adrb), .dinb_i(dinb), .doutb_o(doutb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 0; wea = 0; enb = 0; web = 0;
  endtask

  initial begin
    rst = 1; idle(); adra = '0; adrb = '0; dina = '0; dinb = '0;
    tick(); tick();
    chk("rst_douta", douta, 64'h0);
    chk("rst_doutb", doutb, 64'h0);

    // init contents are zero
    rst = 0;
    enb = 1; adrb = 14'h1234;
    tick(); enb = 0;
    chk("init_b", doutb, 64'h0);
    ena = 1; adra = 14'h1234;
    tick(); ena = 0;
    tick();
    chk("init_a", douta, 64'h0);

    // full write on A, read back on both ports
    ena = 1; wea = 8'hFF; adra = 14'h0010; dina = 64'h0123456789ABCDEF;
    tick(); idle();
    enb = 1; adrb = 14'h0010; ena = 1; adra = 14'h0010;
    tick(); idle();
    chk("xport_b", doutb, 64'h0123456789ABCDEF);
    chk("a_lat1", douta, 64'h0);
    tick();
    chk("a_lat2", douta, 64'h0123456789ABCDEF);

    // byte enables 0x81 on B
    ena = 1; wea = 8'hFF; adra = 14'h0020; dina = 64'h0;
    tick(); idle();
    enb = 1; web = 8'h81; adrb = 14'h0020; dinb = 64'hFFFFFFFFFFFFFFFF;
    tick(); idle();
    ena = 1; adra = 14'h0020;
    tick(); idle();
    tick();
    chk("byte_en", douta, 64'hFF000000000000FF);

    // no-change write mode on B
    ena = 1; wea = 8'hFF; adra = 14'h0001; dina = 64'h11;
    tick();
    adra = 14'h0003; dina = 64'h33;
    tick(); idle();
    enb = 1; adrb = 14'h0001;
    tick();
    chk("b_rd1", doutb, 64'h11);
    web = 8'hFF; adrb = 14'h0002; dinb = 64'h22;
    tick(); idle();
    chk("no_change", doutb, 64'h11);

    // back-to-back A reads
    ena = 1; adra = 14'h0001;
    tick(); adra = 14'h0002;
    tick(); chk("b2b_0", douta, 64'h11); adra = 14'h0003;
    tick(); chk("b2b_1", douta, 64'h22); ena = 0;
    tick(); chk("b2b_2", douta, 64'h33);
    tick(); chk("a_hold", douta, 64'h33);

    // A write / B read same address: B sees old word
    enb = 1; web = 8'hFF; adrb = 14'h0040; dinb = 64'h5555555555555555;
    tick(); idle();
    ena = 1; wea = 8'hFF; adra = 14'h0040; dina = 64'hAAAAAAAAAAAAAAAA;
    enb = 1; adrb = 14'h0040;
    tick(); ena = 0; wea = 0;
    chk("coll_b_old", doutb, 64'h5555555555555555);
    tick(); enb = 0;
    chk("coll_b_new", doutb, 64'hAAAAAAAAAAAAAAAA);

    // B write / A read same address: A sees old word
    ena = 1; adra = 14'h0040; enb = 1; web = 8'hFF; adrb = 14'h0040; dinb = 64'hCCCCCCCCCCCCCCCC;
    tick(); idle();
    tick();
    chk("coll_a_old", douta, 64'hAAAAAAAAAAAAAAAA);

    // both write, A wins on shared bytes
    ena = 1; wea = 8'hFF; adra = 14'h0050; dina = 64'h1111111111111111;
    enb = 1; web = 8'hFF; adrb = 14'h0050; dinb = 64'h2222222222222222;
    tick();
    adra = 14'h0060; wea = 8'h0F; adrb = 14'h0060; web = 8'h3C;
    tick(); idle();
    enb = 1; adrb = 14'h0050;
    tick();
    chk("ww_full", doutb, 64'h1111111111111111);
    adrb = 14'h0060;
    tick(); idle();
    chk("ww_part", doutb, 64'h0000222211111111);

    // reset on a read edge, with a concurrent write
    enb = 1; adrb = 14'h0010;
    ena = 1; wea = 8'hFF; adra = 14'h0070; dina = 64'h7777777777777777;
    rst = 1;
    tick(); idle(); rst = 0;
    chk("rst_rd_b", doutb, 64'h0);
    chk("rst_rd_a", douta, 64'h0);
    tick();
    chk("post_rst_b", doutb, 64'h0);
    chk("post_rst_a", douta, 64'h0);
    enb = 1; adrb = 14'h0070;
    tick(); idle();
    chk("rst_wr_kept", doutb, 64'h7777777777777777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
